// File: rtl/ntt_agu_pkg.sv
// Shared definitions for the NTT address-generation scheduler: FSM encoding
// and default geometry.
package ntt_agu_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_GAP,
    S_DRAIN,
    S_DONE
  } agu_state_e;

  localparam int AGU_D_WIDTH      = 32;
  localparam int AGU_DEGREE_WIDTH = 16;
  localparam int AGU_GAP_CYCLES   = 4;

endpackage

// File: rtl/agu_pair_gen.sv
// Butterfly pair generator: inserts a zero at bit DEGREE_WIDTH-1-stage of the
// pair counter to form the lower index; the upper index sets that bit.
module agu_pair_gen #(
  parameter int D_WIDTH      = 32,
  parameter int DEGREE_WIDTH = 16
) (
  input  logic [DEGREE_WIDTH-2:0] j_i,
  input  logic [D_WIDTH-1:0]      stage_i,
  output logic [D_WIDTH-1:0]      order0_o,
  output logic [D_WIDTH-1:0]      order1_o
);

  logic [D_WIDTH-1:0]      pos;
  logic [DEGREE_WIDTH-1:0] jx;
  logic [DEGREE_WIDTH-1:0] bitp;
  logic [DEGREE_WIDTH-1:0] mask;
  logic [DEGREE_WIDTH-1:0] o0;

  always_comb begin
    pos      = D_WIDTH'(DEGREE_WIDTH - 1) - stage_i;
    jx       = {1'b0, j_i};
    bitp     = DEGREE_WIDTH'(1) << pos;
    mask     = bitp - DEGREE_WIDTH'(1);
    o0       = ((jx & ~mask) << 1) | (jx & mask);
    order0_o = D_WIDTH'(o0);
    order1_o = D_WIDTH'(o0 | bitp);
  end

endmodule

// File: rtl/agu_sched_k2.sv
// Stage scheduler for the K2 AGU: walks every butterfly pair of each NTT stage,
// inserts translator gap cycles between stages and waits for the returned done.
module agu_sched_k2
  import ntt_agu_pkg::*;
#(
  parameter int D_WIDTH      = AGU_D_WIDTH,
  parameter int DEGREE_WIDTH = AGU_DEGREE_WIDTH,
  parameter int GAP_CYCLES   = AGU_GAP_CYCLES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [D_WIDTH-1:0] cfg_stages,
  input  logic               stall,
  input  logic               agu_done_ret,
  output logic [D_WIDTH-1:0] Order_0,
  output logic [D_WIDTH-1:0] Order_1,
  output logic               r_enable_k2,
  output logic               AGU_done_k2,
  output logic [D_WIDTH-1:0] l,
  output logic               busy,
  output logic               done
);

  localparam int JW = DEGREE_WIDTH - 1;
  localparam int GW = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [JW-1:0] J_LAST = '1;

  function automatic logic [D_WIDTH-1:0] clamp_stages(input logic [D_WIDTH-1:0] cfg);
    if (cfg > D_WIDTH'(DEGREE_WIDTH)) return D_WIDTH'(DEGREE_WIDTH);
    return cfg;
  endfunction

  agu_state_e         state_q, state_d;
  logic [JW-1:0]      j_q, j_d;
  logic [D_WIDTH-1:0] stage_q, stage_d;
  logic [D_WIDTH-1:0] nst_q, nst_d;
  logic [GW-1:0]      gap_q, gap_d;

  logic [D_WIDTH-1:0] order0_q, order0_d, order1_q, order1_d, l_q, l_d;
  logic               ren_q, ren_d, agud_q, agud_d, busy_q, busy_d, done_q, done_d;

  // Pair candidate for this edge: IDLE+start issues pair 0 straight away so the
  // first registered pair is visible the cycle after start is sampled.
  logic               cand_vld, issue, last_pair, last_stage;
  logic [JW-1:0]      j_c;
  logic [D_WIDTH-1:0] stage_c, nst_c, cfg_cl, pg_o0, pg_o1;

  always_comb begin
    cfg_cl   = clamp_stages(cfg_stages);
    cand_vld = 1'b0;
    j_c      = j_q;
    stage_c  = stage_q;
    nst_c    = nst_q;
    if (state_q == S_IDLE && start && cfg_cl != '0) begin
      cand_vld = 1'b1;
      j_c      = '0;
      stage_c  = '0;
      nst_c    = cfg_cl;
    end else if (state_q == S_RUN) begin
      cand_vld = 1'b1;
    end
    issue      = cand_vld & ~stall;
    last_pair  = (j_c == J_LAST);
    last_stage = (stage_c == nst_c - D_WIDTH'(1));
  end

  agu_pair_gen #(
    .D_WIDTH      (D_WIDTH),
    .DEGREE_WIDTH (DEGREE_WIDTH)
  ) u_pair_gen (
    .j_i      (j_c),
    .stage_i  (stage_c),
    .order0_o (pg_o0),
    .order1_o (pg_o1)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      j_q      <= '0;
      stage_q  <= '0;
      nst_q    <= '0;
      gap_q    <= '0;
      order0_q <= '0;
      order1_q <= '0;
      l_q      <= '0;
      ren_q    <= 1'b0;
      agud_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      j_q      <= j_d;
      stage_q  <= stage_d;
      nst_q    <= nst_d;
      gap_q    <= gap_d;
      order0_q <= order0_d;
      order1_q <= order1_d;
      l_q      <= l_d;
      ren_q    <= ren_d;
      agud_q   <= agud_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    j_d     = j_q;
    stage_d = stage_q;
    nst_d   = nst_q;
    gap_d   = gap_q;
    case (state_q)
      S_IDLE:  if (start && cfg_cl == '0) state_d = S_DONE;
      S_GAP: begin
        if (int'(gap_q) == GAP_CYCLES - 1) begin
          state_d = S_RUN;
          stage_d = stage_q + D_WIDTH'(1);
          j_d     = '0;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      S_DRAIN: if (agu_done_ret) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: ;
    endcase
    // Stall leaves the candidate pending; only an issued pair advances.
    if (cand_vld) begin
      state_d = S_RUN;
      j_d     = j_c;
      stage_d = stage_c;
      nst_d   = nst_c;
      if (issue) begin
        if (!last_pair) begin
          j_d = j_c + JW'(1);
        end else if (last_stage) begin
          state_d = S_DRAIN;
        end else if (GAP_CYCLES == 0) begin
          stage_d = stage_c + D_WIDTH'(1);
          j_d     = '0;
        end else begin
          state_d = S_GAP;
          gap_d   = '0;
        end
      end
    end
  end

  always_comb begin
    ren_d    = issue;
    order0_d = issue ? pg_o0 : '0;
    order1_d = issue ? pg_o1 : '0;
    l_d      = issue ? stage_c : '0;
    agud_d   = issue & last_pair & last_stage;
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_DONE);
  end

  assign Order_0     = order0_q;
  assign Order_1     = order1_q;
  assign l           = l_q;
  assign r_enable_k2 = ren_q;
  assign AGU_done_k2 = agud_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_agu_sched_k2.sv
// Directed bench for agu_sched_k2 with DEGREE_WIDTH=4 (8 pairs/stage), GAP_CYCLES=4.
module tb_agu_sched_k2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] cfg_stages = '0;
  logic        stall = 1'b0;
  logic        agu_done_ret = 1'b0;
  logic [31:0] Order_0, Order_1, l;
  logic        r_enable_k2, AGU_done_k2, busy, done;

  int n_assert = 0;
  int n_fail   = 0;
  int es, ej, zero_run, npairs;
  bit finished, stalled;

  agu_sched_k2 #(
    .D_WIDTH      (32),
    .DEGREE_WIDTH (4),
    .GAP_CYCLES   (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .cfg_stages   (cfg_stages),
    .stall        (stall),
    .agu_done_ret (agu_done_ret),
    .Order_0      (Order_0),
    .Order_1      (Order_1),
    .r_enable_k2  (r_enable_k2),
    .AGU_done_k2  (AGU_done_k2),
    .l            (l),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Lower index of pair j in stage s for N=16: split j at p, shift the high part up.
  function automatic int exp_o0(input int s, input int j);
    int p;
    p = 3 - s;
    return (j / (1 << p)) * (2 << p) + (j % (1 << p));
  endfunction

  task automatic observe;
    if (r_enable_k2) begin
      chk("pair_o0", Order_0, exp_o0(es, ej));
      chk("pair_o1", Order_1, exp_o0(es, ej) + (1 << (3 - es)));
      chk("pair_l", l, es);
      chk("agu_done_k2", 32'(AGU_done_k2), (es == 3 && ej == 7) ? 1 : 0);
      if (ej == 0 && es != 0) chk("gap_len", zero_run, 4);
      zero_run = 0;
      npairs++;
      ej++;
      if (ej == 8) begin
        ej = 0;
        es++;
      end
    end else begin
      zero_run++;
      chk("idle_zero", Order_0 | Order_1 | l | 32'(AGU_done_k2), 0);
    end
  endtask

  task automatic model_reset;
    es = 0; ej = 0; zero_run = 0; npairs = 0; finished = 0;
  endtask

  initial begin
    // Reset state
    step;
    step;
    chk("rst_ren", 32'(r_enable_k2), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_orders", Order_0 | Order_1 | l, 0);
    rst = 1'b0;
    step;

    // Four-stage run with a 3-cycle stall and a start pulse during RUN
    model_reset();
    stalled = 0;
    start = 1'b1; cfg_stages = 4;
    step;
    start = 1'b0;
    chk("first_o0", Order_0, 0);
    chk("first_o1", Order_1, 8);
    chk("first_ren", 32'(r_enable_k2), 1);
    chk("first_busy", 32'(busy), 1);
    for (int c = 0; c < 300 && !finished; c++) begin
      observe();
      if (AGU_done_k2) begin
        finished = 1;
      end else begin
        if (r_enable_k2 && l == 0 && Order_0 == 4 && !stalled) begin
          stalled = 1;
          stall = 1'b1;
          for (int k = 0; k < 3; k++) begin
            step;
            chk("stall_ren", 32'(r_enable_k2), 0);
          end
          stall = 1'b0;
        end
        start = (c == 15);
        step;
        start = 1'b0;
        if (c == 4 && stalled) begin
          chk("resume_o0", Order_0, 5);
          chk("resume_o1", Order_1, 13);
        end
      end
    end
    chk("run_finished", 32'(finished), 1);
    chk("run_stalled", 32'(stalled), 1);
    chk("run_npairs", npairs, 32);
    chk("last_o0", Order_0, 14);
    chk("last_o1", Order_1, 15);
    chk("last_l", l, 3);

    // Drain until the returned done
    for (int k = 0; k < 6; k++) begin
      step;
      chk("drain_ren", 32'(r_enable_k2), 0);
      chk("drain_busy", 32'(busy), 1);
      chk("drain_done", 32'(done), 0);
    end
    agu_done_ret = 1'b1;
    step;
    agu_done_ret = 1'b0;
    chk("done_pulse", 32'(done), 1);
    step;
    chk("done_clear", 32'(done), 0);
    chk("idle_busy", 32'(busy), 0);

    // Zero stages: straight to DONE with no pairs
    start = 1'b1; cfg_stages = 0;
    step;
    start = 1'b0;
    chk("zero_ren", 32'(r_enable_k2), 0);
    chk("zero_done", 32'(done), 1);
    step;
    chk("zero_done_clear", 32'(done), 0);
    chk("zero_busy", 32'(busy), 0);

    // Oversized stage count clamps to 4 stages
    model_reset();
    start = 1'b1; cfg_stages = 9;
    step;
    start = 1'b0;
    for (int c = 0; c < 300 && !finished; c++) begin
      observe();
      if (AGU_done_k2) finished = 1;
      else step;
    end
    chk("clamp_finished", 32'(finished), 1);
    chk("clamp_npairs", npairs, 32);
    chk("clamp_last_l", l, 3);
    agu_done_ret = 1'b1;
    step;
    agu_done_ret = 1'b0;
    chk("clamp_done", 32'(done), 1);
    step;

    // Asynchronous reset in the middle of stage 2
    finished = 0;
    start = 1'b1; cfg_stages = 4;
    step;
    start = 1'b0;
    for (int c = 0; c < 100 && !finished; c++) begin
      if (r_enable_k2 && l == 2) finished = 1;
      else step;
    end
    chk("reach_stage2", 32'(finished), 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_ren", 32'(r_enable_k2), 0);
    chk("mid_rst_orders", Order_0 | Order_1 | l | 32'(AGU_done_k2), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    start = 1'b1;
    step;
    chk("rst_vs_start_busy", 32'(busy), 0);
    chk("rst_vs_start_ren", 32'(r_enable_k2), 0);
    rst = 1'b0; start = 1'b0;
    step;
    step;
    chk("post_rst_idle_busy", 32'(busy), 0);
    chk("post_rst_idle_ren", 32'(r_enable_k2), 0);
    start = 1'b1;
    step;
    start = 1'b0;
    chk("restart_o0", Order_0, 0);
    chk("restart_o1", Order_1, 8);
    chk("restart_l", l, 0);
    chk("restart_ren", 32'(r_enable_k2), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
